// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the CPU (m0, read/write) and the VGA fetcher (m1, read-only).
// Latency: a request seen in IDLE at cycle N drives s_valid at N+1; ready is combinational from
//   s_ready, so a zero-wait transfer takes 2 cycles including the mandatory IDLE cycle.
// Backpressure: slave wait states stretch the grant; the losing master holds valid until served.
// Config macro: ARB_FAIR_EN (off by default) caps back-to-back m1 grants at MAX_BURST while m0 waits.
// Ports: clk, rst (synchronous, active-high)
//        m0_valid/m0_ready/m0_addr/m0_wdata/m0_wstrb/m0_rdata : CPU master
//        m1_valid/m1_ready/m1_addr/m1_rdata                   : VGA master
//        s_valid/s_ready/s_addr/s_wdata/s_wstrb/s_rdata       : shared RAM slave
//        owner : debug grant indicator, 00 idle / 01 m0 / 10 m1
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_valid,
  output logic                m0_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  output logic                m1_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  input  logic                s_ready,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          owner
);

  // State encoding doubles as the owner debug code.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_fair_force;

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("mem_arbiter: MAX_BURST must be within 1..255");
  end

`ifdef ARB_FAIR_EN
  localparam logic [7:0] LP_MAX_BURST = 8'(MAX_BURST);

  // Counts completed m1 transfers since the CPU was last served (or stopped asking).
  logic [7:0] r_fair_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fair_cnt <= 8'd0;
    end else if (r_state == GNT0 && m0_valid && s_ready) begin
      r_fair_cnt <= 8'd0;
    end else if (r_state == IDLE && !m0_valid) begin
      r_fair_cnt <= 8'd0;
    end else if (r_state == GNT1 && m1_valid && s_ready && r_fair_cnt != 8'hFF) begin
      r_fair_cnt <= r_fair_cnt + 8'd1;
    end
  end

  assign w_fair_force = m0_valid && (r_fair_cnt >= LP_MAX_BURST);
`else
  assign w_fair_force = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state. A grant ends after completion or when the owner withdraws
  // its request (abort); either way IDLE follows for one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m1_valid && !w_fair_force) begin
          w_next = GNT1;
        end else if (m0_valid) begin
          w_next = GNT0;
        end
      end
      GNT0: begin
        if (!m0_valid || s_ready) begin
          w_next = IDLE;
        end
      end
      GNT1: begin
        if (!m1_valid || s_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath mux. Everything is zero in IDLE so s_ready arriving there is ignored.
  always_comb begin
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    owner    = 2'b00;
    case (r_state)
      GNT0: begin
        owner    = 2'b01;
        s_valid  = m0_valid;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready & m0_valid;
        m0_rdata = s_rdata;
      end
      GNT1: begin
        // VGA is read-only: write data and strobes stay zero.
        owner    = 2'b10;
        s_valid  = m1_valid;
        s_addr   = m1_addr;
        m1_ready = s_ready & m1_valid;
        m1_rdata = s_rdata;
      end
      default: begin
      end
    endcase
  end

endmodule
